// File: rtl/rv_wb.sv
// rtl/rv_wb.sv - RISC-V memory-access / write-back stage (Q103H -> Q104H)
module rv_wb #(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_Q103H,
  input  logic [31:0] alu_result_Q103H,
  input  logic [31:0] pc_plus4_Q103H,
  input  logic [4:0]  rd_Q103H,
  input  logic        reg_write_en_Q103H,
  input  logic [1:0]  wb_sel_Q103H,
  input  logic        mem_rd_Q103H,
  input  logic [2:0]  load_funct3_Q103H,
  output logic        ready_Q103H,
  output logic        dmem_req_valid,
  output logic [31:0] dmem_req_addr,
  input  logic        dmem_req_ready,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic [31:0] wb_data_Q104H,
  output logic [4:0]  rd_Q104H,
  output logic        reg_write_en_Q104H,
  output logic        load_err_Q104H
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    ld_rd_q, ld_rd_d;
  logic [2:0]    ld_f3_q, ld_f3_d;
  logic [1:0]    ld_off_q, ld_off_d;
  logic          ld_we_q, ld_we_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    rd_q, rd_d;
  logic          we_q, we_d;
  logic          err_q, err_d;

  logic          misaligned;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [31:0]   alu_sel;

  assign dmem_req_addr = {alu_result_Q103H[31:2], 2'b00};

  always_comb begin
    misaligned = 1'b0;
    case (load_funct3_Q103H)
      3'b001, 3'b101: misaligned = alu_result_Q103H[0];
      3'b010:         misaligned = (alu_result_Q103H[1:0] != 2'b00);
      default:        misaligned = 1'b0;
    endcase
  end

  // Lane selection uses the offset captured at request time, not the live Q103H address.
  assign ld_byte = dmem_rsp_data[{ld_off_q, 3'b000} +: 8];
  assign ld_half = dmem_rsp_data[{ld_off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (ld_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rsp_data;
    endcase
  end

  always_comb begin
    case (wb_sel_Q103H)
      2'd0:    alu_sel = alu_result_Q103H;
      2'd2:    alu_sel = pc_plus4_Q103H;
      default: alu_sel = 32'h0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ld_rd_d        = ld_rd_q;
    ld_f3_d        = ld_f3_q;
    ld_off_d       = ld_off_q;
    ld_we_d        = ld_we_q;
    wb_data_d      = wb_data_q;
    rd_d           = rd_q;
    we_d           = 1'b0;
    err_d          = 1'b0;
    ready_Q103H    = 1'b0;
    dmem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_Q103H && mem_rd_Q103H) begin
          if (misaligned) begin
            ready_Q103H = 1'b1;
            err_d       = 1'b1;
          end else begin
            dmem_req_valid = 1'b1;
            if (dmem_req_ready) begin
              ld_rd_d  = rd_Q103H;
              ld_f3_d  = load_funct3_Q103H;
              ld_off_d = alu_result_Q103H[1:0];
              ld_we_d  = reg_write_en_Q103H;
              cnt_d    = '0;
              state_d  = WAIT_RSP;
            end
          end
        end else if (valid_Q103H) begin
          ready_Q103H = 1'b1;
          wb_data_d   = alu_sel;
          rd_d        = rd_Q103H;
          we_d        = reg_write_en_Q103H && (rd_Q103H != 5'd0);
        end else begin
          ready_Q103H = 1'b1;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + CW'(1);
        // A response on the timeout cycle takes priority over the error.
        if (dmem_rsp_valid) begin
          ready_Q103H = 1'b1;
          wb_data_d   = ld_data;
          rd_d        = ld_rd_q;
          we_d        = ld_we_q && (ld_rd_q != 5'd0);
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ready_Q103H = 1'b1;
          err_d       = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= 5'd0;
      ld_f3_q   <= 3'd0;
      ld_off_q  <= 2'd0;
      ld_we_q   <= 1'b0;
      wb_data_q <= 32'h0;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
      ld_we_q   <= ld_we_d;
      wb_data_q <= wb_data_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      err_q     <= err_d;
    end
  end

  assign wb_data_Q104H      = wb_data_q;
  assign rd_Q104H           = rd_q;
  assign reg_write_en_Q104H = we_q;
  assign load_err_Q104H     = err_q;

endmodule

// File: tb/tb_rv_wb.sv
// tb/tb_rv_wb.sv - directed vector bench for rv_wb
module tb_rv_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_Q103H;
  logic [31:0] alu_result_Q103H;
  logic [31:0] pc_plus4_Q103H;
  logic [4:0]  rd_Q103H;
  logic        reg_write_en_Q103H;
  logic [1:0]  wb_sel_Q103H;
  logic        mem_rd_Q103H;
  logic [2:0]  load_funct3_Q103H;
  logic        ready_Q103H;
  logic        dmem_req_valid;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_ready;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic [31:0] wb_data_Q104H;
  logic [4:0]  rd_Q104H;
  logic        reg_write_en_Q104H;
  logic        load_err_Q104H;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv_wb #(.LOAD_TIMEOUT(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_Q103H        (valid_Q103H),
    .alu_result_Q103H   (alu_result_Q103H),
    .pc_plus4_Q103H     (pc_plus4_Q103H),
    .rd_Q103H           (rd_Q103H),
    .reg_write_en_Q103H (reg_write_en_Q103H),
    .wb_sel_Q103H       (wb_sel_Q103H),
    .mem_rd_Q103H       (mem_rd_Q103H),
    .load_funct3_Q103H  (load_funct3_Q103H),
    .ready_Q103H        (ready_Q103H),
    .dmem_req_valid     (dmem_req_valid),
    .dmem_req_addr      (dmem_req_addr),
    .dmem_req_ready     (dmem_req_ready),
    .dmem_rsp_valid     (dmem_rsp_valid),
    .dmem_rsp_data      (dmem_rsp_data),
    .wb_data_Q104H      (wb_data_Q104H),
    .rd_Q104H           (rd_Q104H),
    .reg_write_en_Q104H (reg_write_en_Q104H),
    .load_err_Q104H     (load_err_Q104H)
  );

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  sel;
    logic        mem_rd;
    logic [2:0]  f3;
    logic        e_ready;
    logic        e_req;
    logic        chk_data;
    logic [31:0] e_wb;
    logic [4:0]  e_rd;
    logic        e_we;
    logic        e_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic we, input logic [1:0] sel,
                       input logic mrd, input logic [2:0] f3);
    valid_Q103H        = v;
    alu_result_Q103H   = alu;
    pc_plus4_Q103H     = pc4;
    rd_Q103H           = rd;
    reg_write_en_Q103H = we;
    wb_sel_Q103H       = sel;
    mem_rd_Q103H       = mrd;
    load_funct3_Q103H  = f3;
  endtask

  task automatic do_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [4:0] rd, input int stall, input int waitn,
                         input logic [31:0] data, input logic [31:0] exp);
    drive(1'b1, addr, 32'h0, rd, 1'b1, 2'd1, 1'b1, f3);
    dmem_req_ready = 1'b0;
    #1;
    for (int s = 0; s < stall; s++) begin
      chk({nm, " stall ready"}, 32'(ready_Q103H), 32'd0);
      chk({nm, " stall req"}, 32'(dmem_req_valid), 32'd1);
      step();
      chk({nm, " stall bubble"}, 32'(reg_write_en_Q104H), 32'd0);
      #1;
    end
    dmem_req_ready = 1'b1;
    #1;
    chk({nm, " req"}, 32'(dmem_req_valid), 32'd1);
    chk({nm, " addr"}, dmem_req_addr, {addr[31:2], 2'b00});
    chk({nm, " accept ready"}, 32'(ready_Q103H), 32'd0);
    step();
    dmem_req_ready = 1'b0;
    for (int w = 0; w < waitn; w++) begin
      #1;
      chk({nm, " wait ready"}, 32'(ready_Q103H), 32'd0);
      chk({nm, " wait req"}, 32'(dmem_req_valid), 32'd0);
      chk({nm, " wait bubble"}, 32'(reg_write_en_Q104H), 32'd0);
      step();
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = data;
    #1;
    chk({nm, " rsp ready"}, 32'(ready_Q103H), 32'd1);
    step();
    dmem_rsp_valid = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    chk({nm, " wb_data"}, wb_data_Q104H, exp);
    chk({nm, " rd"}, 32'(rd_Q104H), 32'(rd));
    chk({nm, " we"}, 32'(reg_write_en_Q104H), 32'd1);
    chk({nm, " err"}, 32'(load_err_Q104H), 32'd0);
    step();
    chk({nm, " we single"}, 32'(reg_write_en_Q104H), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 5'd9, 1'b1, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 5'd5, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_DEAD, 32'h0, 5'd0, 1'b1, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_DEAD, 5'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0777, 32'h0, 5'd7, 1'b1, 2'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 5'd7, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0888, 32'h100, 5'd8, 1'b1, 2'd2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 5'd8, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0999, 32'h200, 5'd9, 1'b1, 2'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 5'd9, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0101, 32'h0, 5'd3, 1'b1, 2'd1, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0201, 32'h0, 5'd3, 1'b1, 2'd1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_0203, 32'h0, 5'd3, 1'b1, 2'd1, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 32'h0000_0055, 32'h0, 5'd3, 1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0055, 5'd3, 1'b0, 1'b0};

    rst = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_data  = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    #1;
    chk("reset wb_data", wb_data_Q104H, 32'h0);
    chk("reset rd", 32'(rd_Q104H), 32'd0);
    chk("reset we", 32'(reg_write_en_Q104H), 32'd0);
    chk("reset err", 32'(load_err_Q104H), 32'd0);
    step();
    step();
    rst = 1'b1;
    chk("reset idle ready", 32'(ready_Q103H), 32'd1);
    chk("reset idle req", 32'(dmem_req_valid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].alu, vecs[i].pc4, vecs[i].rd, vecs[i].we,
            vecs[i].sel, vecs[i].mem_rd, vecs[i].f3);
      #1;
      chk($sformatf("vec%0d ready", i), 32'(ready_Q103H), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d req", i), 32'(dmem_req_valid), 32'(vecs[i].e_req));
      step();
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d wb_data", i), wb_data_Q104H, vecs[i].e_wb);
        chk($sformatf("vec%0d rd", i), 32'(rd_Q104H), 32'(vecs[i].e_rd));
      end
      chk($sformatf("vec%0d we", i), 32'(reg_write_en_Q104H), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d err", i), 32'(load_err_Q104H), 32'(vecs[i].e_err));
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    step();

    do_load("lb", 32'h0000_0103, 3'b000, 5'd10, 0, 3, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0101, 3'b100, 5'd11, 0, 0, 32'h1234_C678, 32'h0000_00C6);
    do_load("lhu", 32'h0000_0102, 3'b101, 5'd12, 2, 0, 32'h8001_0000, 32'h0000_8001);
    do_load("lh", 32'h0000_0102, 3'b001, 5'd13, 0, 1, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lw_edge", 32'h0000_0400, 3'b010, 5'd14, 0, 3, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Timeout: no response ever arrives.
    drive(1'b1, 32'h0000_0200, 32'h0, 5'd4, 1'b1, 2'd1, 1'b1, 3'b010);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    n = 0;
    while (n < 10) begin
      #1;
      if (ready_Q103H) break;
      n++;
      step();
    end
    chk("timeout ready cycle", 32'(n), 32'd3);
    step();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    chk("timeout err", 32'(load_err_Q104H), 32'd1);
    chk("timeout we", 32'(reg_write_en_Q104H), 32'd0);
    chk("timeout wb hold", wb_data_Q104H, 32'hCAFE_BABE);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h1111_1111;
    step();
    dmem_rsp_valid = 1'b0;
    chk("late rsp we", 32'(reg_write_en_Q104H), 32'd0);
    chk("late rsp err", 32'(load_err_Q104H), 32'd0);
    chk("late rsp wb", wb_data_Q104H, 32'hCAFE_BABE);

    // Reset in the middle of a pending load.
    drive(1'b1, 32'h0000_0300, 32'h0, 5'd6, 1'b1, 2'd1, 1'b1, 3'b010);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst wb_data", wb_data_Q104H, 32'h0);
    chk("midrst rd", 32'(rd_Q104H), 32'd0);
    chk("midrst we", 32'(reg_write_en_Q104H), 32'd0);
    chk("midrst err", 32'(load_err_Q104H), 32'd0);
    step();
    rst = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h2222_2222;
    step();
    dmem_rsp_valid = 1'b0;
    chk("post rst rsp we", 32'(reg_write_en_Q104H), 32'd0);
    chk("post rst rsp wb", wb_data_Q104H, 32'h0);
    drive(1'b1, 32'h0000_0000, 32'h0000_0044, 5'd1, 1'b1, 2'd2, 1'b0, 3'd0);
    step();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    chk("jal wb_data", wb_data_Q104H, 32'h0000_0044);
    chk("jal rd", 32'(rd_Q104H), 32'd1);
    chk("jal we", 32'(reg_write_en_Q104H), 32'd1);
    step();
    chk("jal we single", 32'(reg_write_en_Q104H), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
